// File: rtl/irq_pkg.sv
// Shared types, defaults and helpers for the interrupt controller.
package irq_pkg;

    localparam int N_DEFAULT = 8;
    localparam int N_MAX     = 32;
    localparam int VW_MAX    = $clog2(N_MAX);

    // Every source starts out disabled.
    localparam logic [N_MAX-1:0] MASK_RESET = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Index of the lowest set bit; bit 0 has the highest priority.
    // Returns 0 when no bit is set, callers qualify with a separate "any".
    function automatic logic [VW_MAX-1:0] lowest_set_index(input logic [N_MAX-1:0] v);
        logic [VW_MAX-1:0] idx;
        idx = '0;
        for (int i = N_MAX - 1; i >= 0; i--) begin
            if (v[i]) idx = i[VW_MAX-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bundle of request, acknowledge, vector and mask signals between the
// interrupt controller and its surroundings (peripherals, processor, handler).
interface irq_controller_if
    import irq_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int VW = $clog2(N)
);
    logic [N-1:0]  irq;
    logic          nmi_req;
    logic          INA;
    logic          eoi;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;

    logic          INT;
    logic          NMI;
    logic          INTD;
    logic          vec_valid;
    logic [VW-1:0] vec_id;
    logic          vec_nmi;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;

    // Controller side: drives the processor request lines and readback.
    modport master (
        input  irq, nmi_req, INA, eoi, mask_we, mask_wdata,
        output INT, NMI, INTD, vec_valid, vec_id, vec_nmi, pending, mask
    );

    // Environment side: peripherals, processor and handler.
    modport slave (
        output irq, nmi_req, INA, eoi, mask_we, mask_wdata,
        input  INT, NMI, INTD, vec_valid, vec_id, vec_nmi, pending, mask
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of elig wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int VW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    output logic [VW-1:0] idx,
    output logic          any
);

    logic [N_MAX-1:0] elig_ext;

    // Zero-extend to the helper's width, then narrow the result.
    always_comb begin
        elig_ext          = '0;
        elig_ext[N-1:0]   = elig;
        idx               = VW'(lowest_set_index(elig_ext));
        any               = |elig;
    end

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with NMI preemption, in-service
// tracking and LIFO end-of-interrupt release.
//
//   state   | meaning
//   IDLE    | nothing requested; raise INT once a source is eligible
//   REQ     | INT high, waiting for INA (or for eligibility to vanish)
//   SERVICE | maskable handler running, INTD high, INT suppressed
module irq_controller
    import irq_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int VW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_controller_if.master  bus
);

    logic [N-1:0]  irq_q;
    logic [N-1:0]  pending_r;
    logic [N-1:0]  mask_r;
    logic [N-1:0]  rise;
    logic [N-1:0]  elig;
    logic [N-1:0]  clr;
    logic [VW-1:0] win;
    logic          any;

    state_t        state;
    logic          int_r;
    logic          nmi_r;
    logic          intd_r;
    logic          vec_valid_r;
    logic [VW-1:0] vec_id_r;
    logic          vec_nmi_r;

    logic          nmi_q;
    logic          nmi_pend;
    logic          nmi_active;
    logic          nmi_rise;
    logic          nmi_ack;
    logic          int_ack;
    logic          nmi_pend_nx;
    logic          nmi_active_nx;

    irq_prio_enc #(.N(N), .VW(VW)) u_prio_enc (
        .elig (elig),
        .idx  (win),
        .any  (any)
    );

    // Edge detect, acknowledge decode and next NMI bookkeeping.
    always_comb begin
        rise          = bus.irq & ~irq_q;
        elig          = pending_r & ~mask_r;
        nmi_rise      = bus.nmi_req & ~nmi_q;
        // An NMI ack steals INA; the maskable request stays up underneath.
        nmi_ack       = bus.INA & nmi_r;
        int_ack       = bus.INA & int_r & (state == REQ) & any & ~nmi_ack;
        clr           = '0;
        if (int_ack) clr[win] = 1'b1;
        // A fresh rise wins over the ack clearing nmi_pend.
        nmi_pend_nx   = nmi_rise | (nmi_pend & ~nmi_ack);
        // NMI sits on top of the service stack, so any eoi releases it first.
        nmi_active_nx = nmi_ack | (nmi_active & ~bus.eoi);
    end

    // Input history, pending latch (set beats clear) and mask register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q     <= '0;
            nmi_q     <= 1'b0;
            pending_r <= '0;
            mask_r    <= MASK_RESET[N-1:0];
        end else begin
            irq_q     <= bus.irq;
            nmi_q     <= bus.nmi_req;
            pending_r <= (pending_r & ~clr) | rise;
            if (bus.mask_we) mask_r <= bus.mask_wdata;
        end
    end

    // Maskable FSM, NMI path and registered processor-facing outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            int_r       <= 1'b0;
            nmi_r       <= 1'b0;
            intd_r      <= 1'b0;
            vec_valid_r <= 1'b0;
            vec_id_r    <= '0;
            vec_nmi_r   <= 1'b0;
            nmi_pend    <= 1'b0;
            nmi_active  <= 1'b0;
        end else begin
            nmi_pend   <= nmi_pend_nx;
            nmi_active <= nmi_active_nx;
            nmi_r      <= nmi_pend_nx & ~nmi_active_nx;

            if (nmi_ack) begin
                vec_nmi_r   <= 1'b1;
                vec_valid_r <= 1'b1;
            end else if (bus.eoi && nmi_active) begin
                vec_nmi_r   <= 1'b0;
                vec_valid_r <= (state == SERVICE);
            end

            case (state)
                IDLE: begin
                    if (any) begin
                        state <= REQ;
                        int_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (!any) begin
                        state <= IDLE;
                        int_r <= 1'b0;
                    end else if (int_ack) begin
                        state       <= SERVICE;
                        int_r       <= 1'b0;
                        intd_r      <= 1'b1;
                        vec_valid_r <= 1'b1;
                        vec_id_r    <= win;
                        vec_nmi_r   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi && !nmi_active) begin
                        state       <= IDLE;
                        intd_r      <= 1'b0;
                        vec_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    int_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INT       = int_r;
    assign bus.NMI       = nmi_r;
    assign bus.INTD      = intd_r;
    assign bus.vec_valid = vec_valid_r;
    assign bus.vec_id    = vec_id_r;
    assign bus.vec_nmi   = vec_nmi_r;
    assign bus.pending   = pending_r;
    assign bus.mask      = mask_r;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a stack-based reference model predicts
// every post-edge output snapshot; a monitor pops and compares on negedge.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    irq_controller_if #(.N(N)) bus ();

    irq_controller #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       i;
        logic       n;
        logic       d;
        logic       vv;
        logic [2:0] vid;
        logic       vn;
        logic [7:0] pend;
        logic [7:0] msk;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Drive values for the next clock edge.
    logic       d_rst_n;
    logic [7:0] d_irq;
    logic       d_nmi, d_ina, d_eoi, d_mwe;
    logic [7:0] d_mwd;

    // Reference model: sources, mask, NMI flag and a LIFO service stack
    // (-1 marks the NMI, otherwise the maskable source number).
    logic [7:0] m_pend, m_mask, m_irq_q;
    logic       m_nmi_q, m_nmi_pend, m_int, m_nmi;
    int         m_stack[$];
    int         m_last_id;

    function automatic logic has_nmi();
        foreach (m_stack[k]) if (m_stack[k] == -1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic has_mask();
        foreach (m_stack[k]) if (m_stack[k] >= 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.i    = m_int;
        s.n    = m_nmi;
        s.d    = has_mask();
        s.vv   = (m_stack.size() > 0);
        s.vid  = m_last_id[2:0];
        s.vn   = (m_stack.size() > 0) && (m_stack[m_stack.size()-1] == -1);
        s.pend = m_pend;
        s.msk  = m_mask;
        return s;
    endfunction

    task automatic model_step();
        logic [7:0] rise, elig, clr;
        int         win;
        logic       nmi_ack, int_ack, in_svc;
        if (!d_rst_n) begin
            m_pend = '0; m_mask = 8'hFF; m_irq_q = '0; m_nmi_q = 0;
            m_nmi_pend = 0; m_int = 0; m_nmi = 0; m_last_id = 0;
            m_stack.delete();
            return;
        end
        rise = d_irq & ~m_irq_q;
        elig = m_pend & ~m_mask;
        win  = -1;
        for (int i = 0; i < N; i++) if (win < 0 && elig[i]) win = i;
        nmi_ack = d_ina && m_nmi;
        int_ack = d_ina && m_int && !nmi_ack && (win >= 0);
        in_svc  = has_mask();
        m_int   = !in_svc && (win >= 0) && !int_ack;
        if (d_eoi && m_stack.size() > 0) void'(m_stack.pop_back());
        clr = '0;
        if (int_ack) begin
            clr[win] = 1'b1;
            m_stack.push_back(win);
            m_last_id = win;
        end
        if (nmi_ack) m_stack.push_back(-1);
        m_pend = (m_pend & ~clr) | rise;
        if (d_mwe) m_mask = d_mwd;
        if (d_nmi && !m_nmi_q) m_nmi_pend = 1'b1;
        else if (nmi_ack)      m_nmi_pend = 1'b0;
        m_nmi   = m_nmi_pend && !has_nmi();
        m_irq_q = d_irq;
        m_nmi_q = d_nmi;
    endtask

    // One clock: apply inputs, predict, queue the expectation after the edge.
    task automatic cyc();
        snap_t s;
        rst_n          = d_rst_n;
        bus.irq        = d_irq;
        bus.nmi_req    = d_nmi;
        bus.INA        = d_ina;
        bus.eoi        = d_eoi;
        bus.mask_we    = d_mwe;
        bus.mask_wdata = d_mwd;
        model_step();
        s = model_snap();
        @(posedge clk);
        exp_q.push_back(s);
        #1;
        d_rst_n = 1'b1; d_ina = 1'b0; d_eoi = 1'b0; d_mwe = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: compare each post-edge DUT snapshot against the queued model.
    initial begin : monitor
        snap_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                a.i    = bus.INT;
                a.n    = bus.NMI;
                a.d    = bus.INTD;
                a.vv   = bus.vec_valid;
                a.vid  = bus.vec_id;
                a.vn   = bus.vec_nmi;
                a.pend = bus.pending;
                a.msk  = bus.mask;
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL snapshot t=%0t actual={INT,NMI,INTD,vv,id,vn,pend,mask}=%h required=%h",
                             $time, a, e);
                end
            end
        end
    end

    initial begin : stim
        d_rst_n = 1'b0; d_irq = '0; d_nmi = 0; d_ina = 0; d_eoi = 0; d_mwe = 0; d_mwd = '0;
        rst_n = 1'b0;
        bus.irq = '0; bus.nmi_req = 0; bus.INA = 0; bus.eoi = 0; bus.mask_we = 0; bus.mask_wdata = '0;
        @(posedge clk); #1;
        d_rst_n = 1'b0; cyc();
        d_rst_n = 1'b0; cyc();
        chk("reset_mask", bus.mask, 8'hFF);
        chk("reset_outs", {4'b0, bus.INT, bus.NMI, bus.INTD, bus.vec_valid}, 8'h00);

        // Single source: unmask bit 0, request, ack, release.
        d_mwe = 1; d_mwd = 8'hFE; cyc();
        d_irq = 8'h01; cyc();
        chk("pend0_set", bus.pending, 8'h01);
        cyc();
        chk("int_raised", {7'b0, bus.INT}, 8'h01);
        cyc();
        d_ina = 1; cyc();
        chk("ack0_intd_vv", {6'b0, bus.INTD, bus.vec_valid}, 8'h03);
        chk("ack0_int", {7'b0, bus.INT}, 8'h00);
        repeat (4) cyc();
        d_eoi = 1; cyc();
        chk("eoi0_intd_vv", {6'b0, bus.INTD, bus.vec_valid}, 8'h00);
        d_irq = 8'h00; cyc();

        // Two simultaneous sources: lower index first.
        d_mwe = 1; d_mwd = 8'h00; cyc();
        d_irq = 8'h24; cyc();
        cyc();
        d_ina = 1; cyc();
        chk("prio_vec2", {5'b0, bus.vec_id}, 8'h02);
        chk("prio_pend", bus.pending, 8'h20);
        d_eoi = 1; cyc();
        cyc();
        chk("reraise", {7'b0, bus.INT}, 8'h01);
        d_ina = 1; cyc();
        chk("prio_vec5", {5'b0, bus.vec_id}, 8'h05);
        d_eoi = 1; cyc();
        d_irq = 8'h00; cyc();

        // Masked source latches but stays quiet until unmasked.
        d_mwe = 1; d_mwd = 8'hFF; cyc();
        d_irq = 8'h08; cyc(); cyc(); cyc();
        chk("masked_noint", {7'b0, bus.INT}, 8'h00);
        d_mwe = 1; d_mwd = 8'hF7; cyc(); cyc();
        chk("unmask_int", {7'b0, bus.INT}, 8'h01);
        d_mwe = 1; d_mwd = 8'hFF; cyc(); cyc();
        chk("remask_int", {7'b0, bus.INT}, 8'h00);
        chk("remask_pend", bus.pending, 8'h08);

        // NMI nested over a maskable service.
        d_mwe = 1; d_mwd = 8'hFD; cyc();
        d_irq = 8'h0A; cyc(); cyc();
        d_ina = 1; cyc();
        d_nmi = 1; cyc();
        chk("nmi_over_intd", {6'b0, bus.NMI, bus.INTD}, 8'h03);
        d_ina = 1; cyc();
        chk("nmi_vec", {6'b0, bus.vec_nmi, bus.vec_valid}, 8'h03);
        d_eoi = 1; cyc();
        chk("nmi_eoi", {3'b0, bus.vec_nmi, bus.vec_valid, bus.vec_id}, 8'h09);
        d_eoi = 1; cyc();
        chk("mask_eoi", {7'b0, bus.INTD}, 8'h00);

        // INT and NMI together: only the NMI is taken.
        d_nmi = 0; d_mwe = 1; d_mwd = 8'hF7; cyc();
        d_nmi = 1; cyc();
        chk("both_high", {6'b0, bus.INT, bus.NMI}, 8'h03);
        d_ina = 1; cyc();
        chk("both_ack", {6'b0, bus.INT, bus.NMI}, 8'h02);
        chk("both_pend", bus.pending, 8'h08);
        d_eoi = 1; cyc();

        // Reset during nested service, then a stray eoi.
        d_ina = 1; cyc();
        d_nmi = 0; cyc();
        d_nmi = 1; cyc();
        d_ina = 1; cyc();
        d_rst_n = 0; d_irq = 8'h00; d_nmi = 0; cyc();
        chk("rst_mid_mask", bus.mask, 8'hFF);
        chk("rst_mid_outs", {2'b0, bus.INT, bus.NMI, bus.INTD, bus.vec_valid, bus.vec_nmi, 1'b0}, 8'h00);
        d_eoi = 1; cyc();
        chk("stray_eoi", {6'b0, bus.INTD, bus.vec_valid}, 8'h00);

        // Randomized traffic with a processor that respects the LIFO rules.
        for (int c = 0; c < 3000; c++) begin
            d_irq ^= 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 39) == 0) d_nmi = ~d_nmi;
            if ($urandom_range(0, 24) == 0) begin
                d_mwe = 1;
                d_mwd = 8'($urandom) & 8'($urandom);
            end
            if ((m_nmi || (m_int && !has_nmi())) && $urandom_range(0, 2) == 0)
                d_ina = 1;
            else if (!m_int && !m_nmi && $urandom_range(0, 30) == 0)
                d_ina = 1;
            if (!d_ina) begin
                if (m_stack.size() > 0 && $urandom_range(0, 5) == 0) d_eoi = 1;
                else if (m_stack.size() == 0 && $urandom_range(0, 49) == 0) d_eoi = 1;
            end
            if ($urandom_range(0, 499) == 0) d_rst_n = 0;
            cyc();
        end

        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
